sipo_deframer: RTL and testbench

- Serial-in/parallel-out receive stage that sits directly downstream of the piso shifter.
- Consumes its serial_out bit stream and rebuilds WIDTH-bit words, with a start marker for frame alignment.
- Completed words are presented on a valid/ready output holding register.
- Internal shift register is exported for bench observability, as on piso.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_hold_reg.sv | 44 ++++
 rtl/sipo_deframer.sv | 121 ++++++++++++
 tb/tb_sipo_deframer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and constants for the sipo_deframer receive stage.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic RST_ACTIVE = 1'b0;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Valid/ready output holding register for completed words (data plus parity flag),
// with a sticky overrun flag raised when a word arrives while the held one is stalled.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH:0]   load_data,
  input  logic             out_ready,
  output logic [WIDTH:0]   data_out,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH:0] data_reg;
  logic           valid_reg;
  logic           overrun_reg;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (load) begin
      // A consumer draining the held word this cycle frees the slot for the new one.
      if (!valid_reg || out_ready) begin
        data_reg  <= load_data;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign data_out  = data_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer with start-marker alignment and valid/ready output.
// Optional even-parity trailer bit is enabled by defining SIPO_PARITY_EN.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] shift_reg,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] assembly_reg;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shift_next;
  logic             word_load;
  logic [WIDTH:0]   word_data;
  logic [WIDTH:0]   hold_data;

  // A start bit always begins from an empty register, whatever state we are in.
  assign shift_base = start ? '0 : assembly_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign shift_next[gi] = serial_in;
        end else begin : g_mv
          assign shift_next[gi] = shift_base[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign shift_next[gi] = serial_in;
        end else begin : g_mv
          assign shift_next[gi] = shift_base[gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      assembly_reg <= '0;
    end else if (bit_valid) begin
      if (start) begin
        assembly_reg <= shift_next;
        count_reg    <= CW'(1);
        state_reg    <= SHIFT;
      end else begin
        case (state_reg)
          SHIFT: begin
            assembly_reg <= shift_next;
            if (count_reg == LAST) begin
`ifdef SIPO_PARITY_EN
              count_reg <= count_reg + 1'b1;
              state_reg <= PARITY;
`else
              count_reg <= '0;
              state_reg <= IDLE;
`endif
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
          PARITY: begin
            count_reg <= '0;
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SIPO_PARITY_EN
  assign word_load = bit_valid && !start && (state_reg == PARITY);
  assign word_data = {(^assembly_reg) ^ serial_in, assembly_reg};
`else
  assign word_load = bit_valid && !start && (state_reg == SHIFT) && (count_reg == LAST);
  assign word_data = {1'b0, shift_next};
`endif

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (word_load),
    .load_data(word_data),
    .out_ready(out_ready),
    .data_out (hold_data),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  assign shift_reg    = assembly_reg;
  assign parallel_out = hold_data[WIDTH-1:0];
  assign parity_err   = hold_data[WIDTH];
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (WIDTH=4, MSB-first and LSB-first).
module tb_sipo_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       serial_in = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] shift_reg, parallel_out, shift_reg_l, parallel_out_l;
  logic       out_valid, busy, overrun, parity_err;
  logic       out_valid_l, busy_l, overrun_l, parity_err_l;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
    .shift_reg(shift_reg), .parallel_out(parallel_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
    .shift_reg(shift_reg_l), .parallel_out(parallel_out_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .busy(busy_l), .overrun(overrun_l), .parity_err(parity_err_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    $display("check %-20s got=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic s, input logic b);
    start     = s;
    bit_valid = 1'b1;
    serial_in = b;
    @(posedge clk); #1;
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle(2);
    check("rst_shift", shift_reg, 4'b0000);
    check("rst_pout", parallel_out, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    rst = 1'b1;
    idle(1);

`ifdef SIPO_PARITY_EN
    // Data 1011 with correct even parity bit 1.
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b1); send(1'b0, 1'b1);
    check("par_busy_wait", busy, 1'b1);
    check("par_valid_wait", out_valid, 1'b0);
    send(1'b0, 1'b1);
    check("par_ok_valid", out_valid, 1'b1);
    check("par_ok_pout", parallel_out, 4'b1011);
    check("par_ok_perr", parity_err, 1'b0);
    check("par_ok_busy", busy, 1'b0);
    idle(1);
    check("par_ok_drain", out_valid, 1'b0);
    // Same data, wrong parity bit 0.
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b1); send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    check("par_bad_valid", out_valid, 1'b1);
    check("par_bad_pout", parallel_out, 4'b1011);
    check("par_bad_perr", parity_err, 1'b1);
    check("par_bad_overrun", overrun, 1'b0);
`else
    // Data bit without start in IDLE is ignored.
    send(1'b0, 1'b1);
    check("idle_ignore_busy", busy, 1'b0);
    check("idle_ignore_shift", shift_reg, 4'b0000);

    // Frame 1011, consumer always ready.
    send(1'b1, 1'b1);
    check("f1_busy1", busy, 1'b1);
    check("f1_shift1", shift_reg, 4'b0001);
    send(1'b0, 1'b0);
    check("f1_busy2", busy, 1'b1);
    send(1'b0, 1'b1);
    check("f1_busy3", busy, 1'b1);
    check("f1_valid3", out_valid, 1'b0);
    send(1'b0, 1'b1);
    check("f1_valid", out_valid, 1'b1);
    check("f1_pout", parallel_out, 4'b1011);
    check("f1_busy_done", busy, 1'b0);
    idle(1);
    check("f1_valid_drop", out_valid, 1'b0);

    // Stalled consumer: second frame 1100 is dropped.
    out_ready = 1'b0;
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b1); send(1'b0, 1'b1);
    check("f2_valid", out_valid, 1'b1);
    check("f2_overrun0", overrun, 1'b0);
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0);
    check("ovr_pout_kept", parallel_out, 4'b1011);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    idle(1);
    check("ovr_drain", out_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // Resync mid-frame.
    do_reset();
    idle(1);
    check("rs_overrun_clr", overrun, 1'b0);
    send(1'b1, 1'b1); send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    check("rs_shift", shift_reg, 4'b0001);
    check("rs_valid_a", out_valid, 1'b0);
    send(1'b0, 1'b1); send(1'b0, 1'b0);
    check("rs_valid_b", out_valid, 1'b0);
    send(1'b0, 1'b0);
    check("rs_valid", out_valid, 1'b1);
    check("rs_pout", parallel_out, 4'b1100);
    check("rs_overrun", overrun, 1'b0);
    idle(1);
    check("rs_one_pulse", out_valid, 1'b0);

    // Gapped partial frame aborted by reset, then clean frame 0110.
    send(1'b1, 1'b1); idle(3);
    send(1'b0, 1'b0); idle(3);
    send(1'b0, 1'b1); idle(3);
    check("gap_shift", shift_reg, 4'b0101);
    check("gap_busy", busy, 1'b1);
    do_reset();
    check("ab_shift", shift_reg, 4'b0000);
    check("ab_pout", parallel_out, 4'b0000);
    check("ab_busy", busy, 1'b0);
    check("ab_valid", out_valid, 1'b0);
    send(1'b1, 1'b0); send(1'b0, 1'b1); send(1'b0, 1'b1); send(1'b0, 1'b0);
    check("ab_new_valid", out_valid, 1'b1);
    check("ab_new_pout", parallel_out, 4'b0110);
    idle(2);

    // LSB-first instance: bits 1,1,0,1 assemble to 1011.
    send(1'b1, 1'b1);
    check("lsb_shift1", shift_reg_l, 4'b1000);
    send(1'b0, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b1);
    check("lsb_valid", out_valid_l, 1'b1);
    check("lsb_pout", parallel_out_l, 4'b1011);
    check("msb_same_bits", parallel_out, 4'b1101);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
